// File: rtl/sha_nonce_scheduler.sv
// Nonce sweep sequencer for one sha_block core: two passes per nonce, reports the first winner.
// The attached core must be reset by the same reset net so no stale sha_done outlives a reset.
module sha_nonce_scheduler #(
    parameter int NONCE_W = 32,
    parameter int TIMEOUT = 1024,
    parameter int LEN1    = 640
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [95:0]        tail,
    input  logic [NONCE_W-1:0] nonce_first,
    input  logic [NONCE_W-1:0] nonce_last,
    input  logic [255:0]       target,
    output logic               sha_en,
    output logic [511:0]       sha_M,
    input  logic [255:0]       sha_H,
    input  logic               sha_done,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic               timeout_err,
    output logic [NONCE_W-1:0] nonce_o,
    output logic [255:0]       hash_o
);
    localparam int PAD1_W = 512 - 96 - NONCE_W - 1 - 64;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH1,
        S_WAIT1,
        S_LAUNCH2,
        S_WAIT2,
        S_CHECK,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [95:0]        tail_q, tail_d;
    logic [NONCE_W-1:0] cur_q, cur_d;
    logic [NONCE_W-1:0] last_q, last_d;
    logic [255:0]       target_q, target_d;
    logic [511:0]       sha_m_q, sha_m_d;
    logic               sha_en_q, sha_en_d;
    logic               found_q, found_d;
    logic               timeout_err_q, timeout_err_d;
    logic [NONCE_W-1:0] nonce_o_q, nonce_o_d;
    logic [255:0]       hash_o_q, hash_o_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timed_out;

    function automatic logic [511:0] pass1_block(input logic [95:0] t, input logic [NONCE_W-1:0] n);
        return {t, n, 1'b1, {PAD1_W{1'b0}}, 64'(LEN1)};
    endfunction

    // Second pass hashes the 32-byte first digest, so its length field is fixed at 256 bits.
    function automatic logic [511:0] pass2_block(input logic [255:0] h);
        return {h, 1'b1, 191'b0, 64'd256};
    endfunction

    // cnt_q equals the number of cycles elapsed since the last launch pulse.
    assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d       = state_q;
        tail_d        = tail_q;
        cur_d         = cur_q;
        last_d        = last_q;
        target_d      = target_q;
        sha_m_d       = sha_m_q;
        sha_en_d      = 1'b0;
        found_d       = found_q;
        timeout_err_d = timeout_err_q;
        nonce_o_d     = nonce_o_q;
        hash_o_d      = hash_o_q;
        cnt_d         = cnt_q;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        tail_d        = tail;
                        cur_d         = nonce_first;
                        last_d        = nonce_last;
                        target_d      = target;
                        found_d       = 1'b0;
                        timeout_err_d = 1'b0;
                        sha_m_d       = pass1_block(tail, nonce_first);
                        sha_en_d      = 1'b1;
                        state_d       = S_LAUNCH1;
                    end
                end
                S_LAUNCH1: begin
                    cnt_d   = CNT_W'(1);
                    state_d = S_WAIT1;
                end
                S_WAIT1: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (sha_done) begin
                        sha_m_d  = pass2_block(sha_H);
                        sha_en_d = 1'b1;
                        state_d  = S_LAUNCH2;
                    end else if (timed_out) begin
                        timeout_err_d = 1'b1;
                        found_d       = 1'b0;
                        nonce_o_d     = cur_q;
                        state_d       = S_DONE;
                    end
                end
                S_LAUNCH2: begin
                    cnt_d   = CNT_W'(1);
                    state_d = S_WAIT2;
                end
                S_WAIT2: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (sha_done) begin
                        hash_o_d = sha_H;
                        state_d  = S_CHECK;
                    end else if (timed_out) begin
                        timeout_err_d = 1'b1;
                        found_d       = 1'b0;
                        nonce_o_d     = cur_q;
                        state_d       = S_DONE;
                    end
                end
                S_CHECK: begin
                    nonce_o_d = cur_q;
                    if (hash_o_q < target_q) begin
                        found_d = 1'b1;
                        state_d = S_DONE;
                    end else if (cur_q == last_q) begin
                        found_d = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        cur_d    = cur_q + NONCE_W'(1);
                        sha_m_d  = pass1_block(tail_q, cur_q + NONCE_W'(1));
                        sha_en_d = 1'b1;
                        state_d  = S_LAUNCH1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            tail_q        <= '0;
            cur_q         <= '0;
            last_q        <= '0;
            target_q      <= '0;
            sha_m_q       <= '0;
            sha_en_q      <= 1'b0;
            found_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            nonce_o_q     <= '0;
            hash_o_q      <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            tail_q        <= tail_d;
            cur_q         <= cur_d;
            last_q        <= last_d;
            target_q      <= target_d;
            sha_m_q       <= sha_m_d;
            sha_en_q      <= sha_en_d;
            found_q       <= found_d;
            timeout_err_q <= timeout_err_d;
            nonce_o_q     <= nonce_o_d;
            hash_o_q      <= hash_o_d;
            cnt_q         <= cnt_d;
        end
    end

    assign sha_en      = sha_en_q;
    assign sha_M       = sha_m_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done        = (state_q == S_DONE);
    assign found       = found_q;
    assign timeout_err = timeout_err_q;
    assign nonce_o     = nonce_o_q;
    assign hash_o      = hash_o_q;

endmodule

// File: tb/tb_sha_nonce_scheduler.sv
// Bench for sha_nonce_scheduler: stub core with a toy 512->256 hash and a sweep-level reference model.
module tb_sha_nonce_scheduler;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [95:0]  tail_i = '0;
    logic [31:0]  first_i = '0;
    logic [31:0]  last_i = '0;
    logic [255:0] target_i = '0;
    logic         sha_en;
    logic [511:0] sha_M;
    logic [255:0] sha_H = '0;
    logic         sha_done = 1'b0;
    logic         busy, done, found, timeout_err;
    logic [31:0]  nonce_o;
    logic [255:0] hash_o;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int core_lat = 2;
    bit core_mute = 1'b0;
    int cd = 0;
    int stab_err = 0;
    logic [511:0] m_cap = '0;
    int en_cyc[$];
    logic [31:0] tried[$];

    sha_nonce_scheduler #(.NONCE_W(32), .TIMEOUT(16), .LEN1(640)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .tail(tail_i),
        .nonce_first(first_i), .nonce_last(last_i), .target(target_i),
        .sha_en(sha_en), .sha_M(sha_M), .sha_H(sha_H), .sha_done(sha_done),
        .busy(busy), .done(done), .found(found), .timeout_err(timeout_err),
        .nonce_o(nonce_o), .hash_o(hash_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] core_hash(input logic [511:0] m);
        logic [255:0] h;
        logic [31:0]  w;
        h = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
        for (int i = 0; i < 24; i++) begin
            w = (m[(i % 16) * 32 +: 32] ^ h[255:224]) * 32'h9E3779B1;
            w = w ^ (w >> 15) ^ h[31:0];
            h = {h[223:0], w};
        end
        return h;
    endfunction

    // Stub core: answers L cycles after each launch pulse, unless muted.
    always @(negedge clk) begin
        if (!reset) begin
            cd <= 0;
            sha_done <= 1'b0;
        end else if (sha_en) begin
            en_cyc.push_back(cyc);
            if (sha_M[63:0] == 64'd640) tried.push_back(sha_M[415:384]);
            m_cap <= sha_M;
            cd <= core_lat;
            sha_done <= 1'b0;
        end else begin
            sha_done <= (cd == 1) && !core_mute;
            if (cd == 1) sha_H <= core_hash(m_cap);
            if (cd > 0) begin
                cd <= cd - 1;
                if (sha_M !== m_cap) stab_err <= stab_err + 1;
            end
        end
    end

    function automatic logic [255:0] dhash(input logic [95:0] tl, input logic [31:0] n);
        logic [255:0] h1;
        h1 = core_hash({tl, n, 1'b1, 319'b0, 64'd640});
        return core_hash({h1, 1'b1, 191'b0, 64'd256});
    endfunction

    task automatic model(input logic [31:0] f, input logic [31:0] l, input logic [255:0] tg,
                         input logic [95:0] tl, output bit fnd, output logic [31:0] n_o,
                         output logic [255:0] h_o, output int cnt);
        logic [31:0] n;
        n = f; cnt = 0; fnd = 0; n_o = f; h_o = '0;
        for (int k = 0; k < 64; k++) begin
            cnt++;
            h_o = dhash(tl, n);
            n_o = n;
            if (h_o < tg) begin fnd = 1; break; end
            if (n == l) break;
            n = n + 32'd1;
        end
    endtask

    task automatic do_run(input logic [31:0] f, input logic [31:0] l, input logic [255:0] tg,
                          input logic [95:0] tl, input int budget, input int glitch_at,
                          output bit got_done, output int done_cyc);
        @(negedge clk);
        tail_i = tl; first_i = f; last_i = l; target_i = tg; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got_done = 0; done_cyc = 0;
        for (int i = 0; i < budget && !got_done; i++) begin
            @(negedge clk); #1;
            if (i == glitch_at) begin start = 1'b1; first_i = ~f; last_i = ~l; target_i = '1; end
            else start = 1'b0;
            if (done === 1'b1) begin got_done = 1; done_cyc = cyc; end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
        vectors++; if (found !== 1'b0 || timeout_err !== 1'b0) begin miscompares++; $display("FAIL reset_flags got %b%b want 00", found, timeout_err); end
        vectors++; if (sha_en !== 1'b0) begin miscompares++; $display("FAIL reset_sha_en got %b want 0", sha_en); end
        vectors++; if (sha_M !== 512'd0) begin miscompares++; $display("FAIL reset_sha_M got %h want 0", sha_M); end
        vectors++; if (nonce_o !== 32'd0 || hash_o !== 256'd0) begin miscompares++; $display("FAIL reset_outs got %h %h want 0 0", nonce_o, hash_o); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // One full sweep checked against the model: result, pulse count, ordering and latency.
    task automatic check_sweep(input string nm, input logic [31:0] f, input logic [31:0] l,
                               input logic [255:0] tg, input logic [95:0] tl, input int lat, input int glitch_at);
        bit fnd, got; logic [31:0] en; logic [255:0] eh; int cnt, dc, base_e, base_t, meas;
        core_lat = lat;
        model(f, l, tg, tl, fnd, en, eh, cnt);
        base_e = en_cyc.size(); base_t = tried.size();
        do_run(f, l, tg, tl, cnt * (2 * lat + 3) + 40, glitch_at, got, dc);
        meas = (en_cyc.size() > base_e) ? dc - en_cyc[base_e] : -1;
        vectors++; if (!got) begin miscompares++; $display("FAIL %s done got 0 want 1", nm); end
        vectors++; if (found !== fnd) begin miscompares++; $display("FAIL %s found got %b want %b", nm, found, fnd); end
        vectors++; if (nonce_o !== en) begin miscompares++; $display("FAIL %s nonce_o got %h want %h", nm, nonce_o, en); end
        vectors++; if (hash_o !== eh) begin miscompares++; $display("FAIL %s hash_o got %h want %h", nm, hash_o, eh); end
        vectors++; if (timeout_err !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL %s tmo/busy got %b%b want 00", nm, timeout_err, busy); end
        vectors++; if (en_cyc.size() - base_e != 2 * cnt) begin miscompares++; $display("FAIL %s sha_en_pulses got %0d want %0d", nm, en_cyc.size() - base_e, 2 * cnt); end
        vectors++; if (meas != cnt * (2 * lat + 3)) begin miscompares++; $display("FAIL %s latency got %0d want %0d", nm, meas, cnt * (2 * lat + 3)); end
        for (int i = 0; i < cnt; i++) begin
            vectors++;
            if (base_t + i >= tried.size() || tried[base_t + i] !== f + 32'(i)) begin
                miscompares++; $display("FAIL %s order idx %0d got %h want %h", nm, i,
                    (base_t + i < tried.size()) ? tried[base_t + i] : 32'hx, f + 32'(i));
            end
        end
    endtask

    task automatic test_single();
        check_sweep("single", 32'd5, 32'd5, '1, 96'h0123456789abcdef01234567, 2, -1);
    endtask

    task automatic test_target_zero();
        check_sweep("target0", 32'd0, 32'd3, '0, 96'hfeedfacecafebeef00112233, 1, -1);
    endtask

    task automatic test_winner();
        logic [95:0] tl; logic [255:0] tg;
        tl = 96'h4b1e5e4a_29ab5f49_ffff001d;
        tg = dhash(tl, 32'h7C2BAC1D) + 256'd1;
        check_sweep("winner", 32'h7C2BAC18, 32'h7C2BAC1F, tg, tl, 3, -1);
        vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL winner_found got %b want 1", found); end
    endtask

    task automatic test_wrap();
        check_sweep("wrap", 32'hFFFFFFFE, 32'h00000001, '0, 96'h55aa55aa55aa55aa55aa55aa, 2, -1);
    endtask

    task automatic test_random();
        logic [31:0] f, l; logic [255:0] tg; logic [95:0] tl;
        for (int it = 0; it < 8; it++) begin
            f  = ($urandom_range(0, 2) == 0) ? 32'hFFFFFFFF - 32'($urandom_range(0, 3)) : 32'($urandom);
            l  = f + 32'($urandom_range(0, 4));
            tg = {32'($urandom_range(0, 32'h3000_0000)), 224'($urandom)};
            tl = {32'($urandom), 32'($urandom), 32'($urandom)};
            check_sweep("random", f, l, tg, tl, int'($urandom_range(1, 6)), -1);
        end
    endtask

    task automatic test_start_ignored();
        check_sweep("start_ignored", 32'd10, 32'd13, '0, 96'h13579bdf02468ace13579bdf, 2, 6);
    endtask

    task automatic test_abort();
        bit fnd, got, hit; logic [31:0] en; logic [255:0] eh; int cnt, dc, base_e;
        core_lat = 3;
        model(32'd9, 32'd9, '0, 96'habcdef, fnd, en, eh, cnt);
        do_run(32'd9, 32'd9, '0, 96'habcdef, 60, -1, got, dc);
        base_e = en_cyc.size();
        @(negedge clk);
        first_i = 32'd0; last_i = 32'd20; target_i = '0; tail_i = 96'h1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk); #1;
            if (sha_done === 1'b1 && en_cyc.size() - base_e == 2) hit = 1;
        end
        vectors++; if (!hit) begin miscompares++; $display("FAIL abort_reach_wait2 got 0 want 1"); end
        abort = 1'b1;
        @(negedge clk); #1;
        abort = 1'b0;
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL abort_idle busy/done got %b%b want 00", busy, done); end
        vectors++; if (hash_o !== eh) begin miscompares++; $display("FAIL abort_hash_kept got %h want %h", hash_o, eh); end
        vectors++; if (nonce_o !== 32'd9) begin miscompares++; $display("FAIL abort_nonce_kept got %h want 9", nonce_o); end
        repeat (4) @(negedge clk);
        #1;
        vectors++; if (en_cyc.size() - base_e != 2 || busy !== 1'b0) begin miscompares++; $display("FAIL abort_stays_idle pulses got %0d want 2", en_cyc.size() - base_e); end
        check_sweep("after_abort", 32'd40, 32'd42, {32'h2000_0000, 224'd0}, 96'h77, 2, -1);
    endtask

    task automatic test_timeout();
        bit got; int dc, base_e, meas;
        core_mute = 1'b1;
        base_e = en_cyc.size();
        do_run(32'h20, 32'h30, '0, 96'h9, 100, -1, got, dc);
        meas = (en_cyc.size() > base_e) ? dc - en_cyc[base_e] : -1;
        vectors++; if (!got) begin miscompares++; $display("FAIL timeout_done got 0 want 1"); end
        vectors++; if (timeout_err !== 1'b1 || found !== 1'b0) begin miscompares++; $display("FAIL timeout_flags got tmo=%b found=%b want 1 0", timeout_err, found); end
        vectors++; if (nonce_o !== 32'h20) begin miscompares++; $display("FAIL timeout_nonce got %h want 20", nonce_o); end
        vectors++; if (meas != 16) begin miscompares++; $display("FAIL timeout_cycles got %0d want 16", meas); end
        vectors++; if (en_cyc.size() - base_e != 1) begin miscompares++; $display("FAIL timeout_pulses got %0d want 1", en_cyc.size() - base_e); end
    endtask

    task automatic test_async_reset();
        int base_e; bit seen;
        core_mute = 1'b1;
        base_e = en_cyc.size();
        @(negedge clk);
        first_i = 32'h55; last_i = 32'h60; target_i = '0; tail_i = 96'h3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); #1; seen = (en_cyc.size() > base_e); end
        repeat (3) @(negedge clk);
        #1;
        vectors++; if (busy !== 1'b1 || !seen) begin miscompares++; $display("FAIL areset_in_wait1 busy got %b want 1", busy); end
        reset = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0 || done !== 1'b0 || sha_en !== 1'b0) begin miscompares++; $display("FAIL areset_ctrl busy/done/en got %b%b%b want 000", busy, done, sha_en); end
        vectors++; if (found !== 1'b0 || timeout_err !== 1'b0) begin miscompares++; $display("FAIL areset_flags got %b%b want 00", found, timeout_err); end
        vectors++; if (sha_M !== 512'd0 || nonce_o !== 32'd0 || hash_o !== 256'd0) begin miscompares++; $display("FAIL areset_data got %h %h want 0 0", nonce_o, hash_o); end
        @(negedge clk); #1;
        reset = 1'b1;
        core_mute = 1'b0;
        check_sweep("after_reset", 32'd100, 32'd101, '0, 96'h4, 1, -1);
        vectors++; if (stab_err != 0) begin miscompares++; $display("FAIL sha_M_stable_in_wait got %0d changes want 0", stab_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_target_zero();
        test_winner();
        test_wrap();
        test_random();
        test_start_ignored();
        test_abort();
        test_timeout();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
